// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler pacing bytes from NUM_REQ producers into one UART
// transmitter, with message locking. Define UART_ARB_TIMEOUT_EN to build the HOLD lock-release timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 10,
    parameter int TIMEOUT      = 255
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_flag
);

    localparam int unsigned NR  = NUM_REQ;
    localparam int          IDW = $clog2(NUM_REQ);
    localparam int          CW  = $clog2(FRAME_CYCLES);

    if (NUM_REQ < 2 || NUM_REQ > 8 || FRAME_CYCLES < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic               lock_q, lock_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] valid_eff;
    logic               arb_found;
    logic [IDW-1:0]     arb_idx;
    logic               issue;
    logic [IDW-1:0]     issue_idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int HCW = $clog2(TIMEOUT + 1);
    logic [HCW-1:0] hold_q, hold_d;
    logic           tmo_q, tmo_d;
`endif

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NR) s = s - NR;
        return IDW'(s);
    endfunction

    // The requester being acked this cycle has not yet dropped its valid.
    assign valid_eff = req_valid & ~ack_q;

    always_comb begin
        logic [IDW-1:0] cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            cand = wrap_add(rr_q, k);
            if (!arb_found && valid_eff[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        lock_d     = lock_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        issue      = 1'b0;
        issue_idx  = grant_q;
`ifdef UART_ARB_TIMEOUT_EN
        hold_d     = hold_q;
        tmo_d      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    issue     = 1'b1;
                    issue_idx = arb_idx;
                end
            end
            SEND: begin
                if (cnt_q == CW'(FRAME_CYCLES - 1)) begin
                    if (lock_q) begin
                        if (valid_eff[grant_q]) begin
                            issue = 1'b1;
                        end else begin
                            state_d = HOLD;
`ifdef UART_ARB_TIMEOUT_EN
                            hold_d  = '0;
`endif
                        end
                    end else if (arb_found) begin
                        issue     = 1'b1;
                        issue_idx = arb_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (valid_eff[grant_q]) begin
                    issue = 1'b1;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (hold_q == HCW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    lock_d  = 1'b0;
                    rr_d    = wrap_add(grant_q, 32'd1);
                    tmo_d   = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Every issue path shares the same bookkeeping; a last byte completes the message.
        if (issue) begin
            state_d            = SEND;
            cnt_d              = '0;
            tx_valid_d         = 1'b1;
            ack_d[issue_idx]   = 1'b1;
            tx_data_d          = req_data[8*issue_idx +: 8];
            grant_d            = issue_idx;
            if (req_last[issue_idx]) begin
                lock_d = 1'b0;
                rr_d   = wrap_add(issue_idx, 32'd1);
            end else begin
                lock_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_q       <= '0;
            grant_q    <= '0;
            lock_q     <= 1'b0;
            ack_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            lock_q     <= lock_d;
            ack_q      <= ack_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            tmo_q  <= tmo_d;
        end
    end
    assign timeout_flag = tmo_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign req_ack  = ack_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares a single UART transmit FSM between `NUM_REQ` byte producers. It accepts bytes through per-requester valid/ack handshakes and paces them into the transmitter one frame at a time. Multi-byte messages are kept contiguous by locking the grant until the byte flagged `last` is sent. It sits directly in front of the transmitter, driving its `dataValid` and `letter_in` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `FRAME_CYCLES`, 10: minimum CLK cycles between successive `tx_valid` pulses, matching 1 start + 8 data + 1 stop at one bit per CLK. Must be ≥ 2.
- `TIMEOUT`, 255: lock-release timeout in cycles. Used only with `UART_ARB_TIMEOUT_EN`.
- `CLK  in  1`: clock.
- `RST  in  1`: reset, synchronous, active-high.
- `req_valid  in  NUM_REQ`: per-requester byte available.
- `req_data  in  8*NUM_REQ`: byte for requester i on bits `[8i+7:8i]`.
- `req_last  in  NUM_REQ`: byte is the final byte of the requester's message.
- `req_ack  out  NUM_REQ`: one-cycle pulse when that requester's byte is taken.
- `tx_valid  out  1`: one-cycle pulse to the transmitter's `dataValid`.
- `tx_data  out  8`: byte to the transmitter's `letter_in`. Held stable from issue until the next issue.
- `grant_id  out  $clog2(NUM_REQ)`: index of the current or most recent grantee.
- `busy  out  1`: high whenever the state is not IDLE.
- `timeout_flag  out  1`: one-cycle pulse when a lock is force-released.

## Operation
- **States:** IDLE, SEND, HOLD. All outputs are registered.
- **Reset:** state=IDLE, rr_ptr=0, lock=0, frame counter=0. `req_ack`, `tx_valid`, `tx_data`, `grant_id`, `busy`, `timeout_flag` are all 0.
- **Arbitration:**
  - Pick the first asserted `req_valid` scanning upward from rr_ptr, modulo `NUM_REQ`.
  - When a message completes (last byte issued, or timeout), rr_ptr becomes grant+1 mod `NUM_REQ`.
- **IDLE:** if any `req_valid` is high, arbitrate. On the next cycle enter SEND with `tx_valid`=1, `req_ack[g]`=1, `tx_data`=`req_data[g]`, `grant_id`=g.
  - lock=1 if `req_last[g]`=0.
- **SEND:** the frame counter runs 0..`FRAME_CYCLES`-1, with the issue cycle as count 0. The decision is made at count `FRAME_CYCLES`-1, using the current-cycle inputs:
  - **Locked, grantee valid:** issue the grantee's next byte in the following cycle and stay in SEND.
  - **Locked, grantee not valid:** go to HOLD. Other requesters are ignored.
  - **Unlocked, any valid:** arbitrate and issue in the following cycle, back-to-back.
  - **Unlocked, none valid:** go to IDLE.
- **HOLD:** when the grantee's `req_valid` is seen, issue on the next cycle and enter SEND. All other requests are ignored.
- **Requester rules:**
  - Hold `req_valid`, `req_data` and `req_last` stable until `req_ack`.
  - `req_valid` is not sampled for the acked requester during its ack cycle.
  - Withdrawing an un-acked request is permitted and has no side effects.
- **Reset mid-frame:** the frame is aborted with no further `tx_valid` or `req_ack`. Lock and rr_ptr are cleared, and pending requests are re-arbitrated from index 0 after RST deasserts.

## Timing
- Request seen in IDLE at cycle N: `tx_valid`/`req_ack` at cycle N+1.
- Issues are spaced exactly `FRAME_CYCLES` cycles apart when data is continuously available. This means the next issue coincides with the transmitter's stop-bit cycle.
- HOLD: grantee valid at cycle M → issue at M+1.
- `busy` falls in the cycle after count `FRAME_CYCLES`-1 when returning to IDLE.
- `req_ack` is one-hot or zero in every cycle.

## Configuration
- **`UART_ARB_TIMEOUT_EN` defined:**
  - A counter runs while in HOLD.
  - After `TIMEOUT` consecutive HOLD cycles without grantee `req_valid`: clear lock, advance rr_ptr, pulse `timeout_flag` for one cycle, and go to IDLE.
  - The counter resets on every entry to HOLD.
- **Not defined:** HOLD waits indefinitely, the timeout counter is not built, and `timeout_flag` is tied to 0.

## Test plan
- **Single byte:** req0 valid, data=0x41, last=1 at cycle 0 → `tx_valid`, `req_ack[0]`, `tx_data`=0x41 at cycle 1. `busy`=1 for cycles 1..10, 0 at cycle 11.
- **Contention:** all four valid with last=1 and data 0x10..0x13 → issues in order 0,1,2,3 at cycles 1, 11, 21, 31.
- **Lock:** req1 sends 0xA0, 0xA1, 0xA2 (last on 0xA2) while req2 holds valid → req1 bytes at t, t+10, t+20, then req2 at t+30.
- **Fairness:** after grant 3 completes, req0 and req3 both valid → req0 granted.
- **Reset mid-frame:** RST at frame count 5 → all outputs 0 the next cycle, state IDLE. With req2 and req3 still valid after release → req2 granted first.
- **Timeout** (`UART_ARB_TIMEOUT_EN`, `TIMEOUT`=20): req0 sends a non-last byte and then drops valid, req1 valid → HOLD for 20 cycles, then one `timeout_flag` pulse, then req1 issued. With the macro off, req1 is never granted.
